// File: rtl/seq_divider16_if.sv
// Handshake/bus bundle for seq_divider16.
// master: operand producer / result consumer. slave: the divider.
// Signals: in_valid/in_ready + dividend/divisor (operand side),
//          out_valid/out_ready + quotient/remainder/div_by_zero (result side).
// With SIGNED_DIV_EN defined, also carries sign_mode (to divider) and overflow (from divider).
interface seq_divider16_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
`ifdef SIGNED_DIV_EN
  logic             sign_mode;
  logic             overflow;

  modport master (
    output in_valid, dividend, divisor, out_ready, sign_mode,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );
  modport slave (
    input  in_valid, dividend, divisor, out_ready, sign_mode,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );
`else
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
`endif
endinterface

// File: rtl/seq_divider16.sv
// Sequential restoring divider: one quotient bit per cycle, valid/ready on both sides.
// Ports: clk, rst (synchronous, active high), bus (seq_divider16_if.slave).
// Optional macro SIGNED_DIV_EN: adds sign_mode/overflow; two's-complement operands are
// divided as magnitudes and the signs are fixed up in the final iteration.
module seq_divider16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  seq_divider16_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   pr_q, pr_d;     // partial remainder
  logic [WIDTH-1:0]   qr_q, qr_d;     // dividend bits shifting out / quotient bits shifting in
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [WIDTH:0]     shifted;
  logic [WIDTH+1:0]   trial;
  logic               fit;
  logic [WIDTH-1:0]   pr_next;
  logic [WIDTH-1:0]   qr_next;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

`ifdef SIGNED_DIV_EN
  logic               ovf_q, ovf_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               a_neg, b_neg, ovf_case;
`endif

  // Operand magnitudes fed to the unsigned core
  always_comb begin
`ifdef SIGNED_DIV_EN
    a_neg    = bus.sign_mode & bus.dividend[WIDTH-1];
    b_neg    = bus.sign_mode & bus.divisor[WIDTH-1];
    a_mag    = a_neg ? WIDTH'(-bus.dividend) : bus.dividend;
    b_mag    = b_neg ? WIDTH'(-bus.divisor)  : bus.divisor;
    ovf_case = bus.sign_mode && (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&bus.divisor);
`else
    a_mag = bus.dividend;
    b_mag = bus.divisor;
`endif
  end

  // One restoring step; extra top bit of trial acts as the borrow/sign
  always_comb begin
    shifted = {pr_q, qr_q[WIDTH-1]};
    trial   = {1'b0, shifted} - {2'b00, dvs_q};
    fit     = ~trial[WIDTH+1];
    pr_next = fit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    qr_next = {qr_q[WIDTH-2:0], fit};
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    dbz_d       = dbz_q;
    pr_d        = pr_q;
    qr_d        = qr_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
`ifdef SIGNED_DIV_EN
    ovf_d       = ovf_q;
    ovf_pend_d  = ovf_pend_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          in_ready_d = 1'b0;
`ifdef SIGNED_DIV_EN
          ovf_d      = 1'b0;
          ovf_pend_d = ovf_case;
          qneg_d     = a_neg ^ b_neg;
          rneg_d     = a_neg;
`endif
          if (bus.divisor == '0) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            quot_d      = '1;
            rem_d       = bus.dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = RUN;
            dbz_d   = 1'b0;
            pr_d    = '0;
            qr_d    = a_mag;
            dvs_d   = b_mag;
            cnt_d   = CNT_W'(WIDTH);
          end
        end
      end
      RUN: begin
        pr_d  = pr_next;
        qr_d  = qr_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
`ifdef SIGNED_DIV_EN
          quot_d = qneg_q ? WIDTH'(-qr_next) : qr_next;
          rem_d  = rneg_q ? WIDTH'(-pr_next) : pr_next;
          ovf_d  = ovf_pend_q;
`else
          quot_d = qr_next;
          rem_d  = pr_next;
`endif
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
      dbz_q       <= 1'b0;
      pr_q        <= '0;
      qr_q        <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
`ifdef SIGNED_DIV_EN
      ovf_q       <= 1'b0;
      ovf_pend_q  <= 1'b0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      dbz_q       <= dbz_d;
      pr_q        <= pr_d;
      qr_q        <= qr_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
`ifdef SIGNED_DIV_EN
      ovf_q       <= ovf_d;
      ovf_pend_q  <= ovf_pend_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
`endif
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
`ifdef SIGNED_DIV_EN
  assign bus.overflow    = ovf_q;
`endif

endmodule

// File: doc/seq_divider16.md
Name: seq_divider16

Overview:
- Sequential restoring unsigned integer divider; the inverse-operation counterpart to the team's 16-bit carry-select adder/subtractor.
- Computes quotient and remainder, one bit per cycle, by repeated trial subtraction of the shifted divisor.
- Sits beside the adder in the datapath. Operands arrive and results leave through valid/ready handshakes.

Parameters:
- WIDTH, 16: operand, quotient and remainder width in bits; legal range 4 to 32.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair present on dividend/divisor.
- in_ready  output  1  block can accept operands (high only in IDLE).
- dividend  input  WIDTH  numerator.
- divisor  input  WIDTH  denominator.
- out_valid  output  1  result registers hold a valid result.
- out_ready  input  1  consumer accepts the result.
- quotient  output  WIDTH  result quotient.
- remainder  output  WIDTH  result remainder.
- div_by_zero  output  1  the current result came from divisor == 0.

Behaviour:
- Reset values when rst is high at a clock edge:
  - state = IDLE, in_ready = 1, out_valid = 0.
  - quotient = 0, remainder = 0, div_by_zero = 0, internal bit counter = 0.
  - rst overrides every other input, including mid-division and while a result is pending; any operation in progress is discarded.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - Handshake: in_valid & in_ready at an edge captures dividend and divisor.
  - If divisor != 0: load partial remainder = 0, load quotient shift register = dividend, counter = WIDTH, go to RUN.
  - If divisor == 0: go straight to DONE with quotient = all ones, remainder = dividend, div_by_zero = 1.
- RUN:
  - in_ready = 0. Executes one iteration per cycle.
  - Shift {partial remainder, quotient register} left by one.
  - trial = partial remainder − divisor, computed at WIDTH+1 bits.
  - If trial is non-negative: partial remainder = trial, quotient LSB = 1. Otherwise keep the partial remainder and set quotient LSB = 0.
  - Decrement the counter; after the iteration where counter reaches 0, go to DONE.
- DONE:
  - out_valid = 1, in_ready = 0.
  - quotient, remainder and div_by_zero are held stable while out_ready = 0, for any number of cycles.
  - out_valid & out_ready at an edge returns to IDLE; out_valid falls the next cycle.
  - Outputs hold their last value in IDLE; div_by_zero clears on the next capture.
- Latency, with the capture edge as cycle 0:
  - Nonzero divisor: out_valid is high from cycle WIDTH+1 (17 at default).
  - Zero divisor: out_valid is high from cycle 1.
- Throughput: one operation at a time. A new operand pair cannot be captured in the same edge as result acceptance; it is accepted in IDLE one cycle later.
- in_valid while busy is ignored; dividend and divisor are not sampled outside the IDLE handshake.
- Arithmetic invariant for unsigned operands: dividend = quotient × divisor + remainder, with remainder < divisor. No overflow is possible in unsigned mode.
- Boundary cases:
  - dividend < divisor gives q = 0, r = dividend.
  - dividend = 0 gives q = 0, r = 0.
  - divisor = 1 gives q = dividend, r = 0.

Optional Feature:
- Macro: SIGNED_DIV_EN.
- Defined:
  - Adds input port sign_mode (1 bit), sampled at capture. sign_mode = 1 selects two's-complement operands.
  - Magnitudes are divided by the same unsigned core.
  - The quotient is negated when operand signs differ; quotient truncates toward zero.
  - The remainder takes the dividend's sign.
  - Negation happens in the final RUN iteration, so latency is unchanged.
  - Most-negative / −1 returns quotient = most-negative value, remainder = 0, and adds output overflow = 1 for that result. overflow is 0 otherwise and 0 at reset.
  - Divide by zero in signed mode returns quotient = all ones, remainder = dividend, div_by_zero = 1.
- Undefined: no sign_mode or overflow ports; all operands are unsigned.

Test Plan:
- Basic division: dividend = 100, divisor = 7, out_ready held 1 → out_valid rises at cycle 17; quotient = 14, remainder = 2, div_by_zero = 0; in_ready returns to 1 at cycle 18.
- Divide by zero: dividend = 0x1234, divisor = 0 → out_valid at cycle 1; quotient = 0xFFFF, remainder = 0x1234, div_by_zero = 1.
- Extremes:
  - 0xFFFF / 0x0001 → q = 0xFFFF, r = 0.
  - 0x0005 / 0xFFFF → q = 0, r = 5.
  - 0 / 3 → q = 0, r = 0.
- Backpressure: out_ready held 0 for 10 cycles after out_valid, with in_valid = 1 and new operands toggling → in_ready = 0 throughout, outputs unchanged. Raise out_ready → result consumed; next operand captured one cycle later.
- Reset mid-operation: assert rst at cycle 8 of 200 / 9 → next cycle state = IDLE, in_ready = 1, out_valid = 0, outputs 0. A following 81 / 9 gives q = 9, r = 0.
- SIGNED_DIV_EN build:
  - −7 / 2 → q = 0xFFFD, r = 0xFFFF.
  - 7 / −2 → q = 0xFFFD, r = 1.
  - 0x8000 / 0xFFFF → q = 0x8000, r = 0, overflow = 1.
  - Random operands checked against a reference model.
